// File: rtl/reg_writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue_pkg
// Purpose  : Shared processor constants for the writeback queue slice.
// Revision : 1.0 - initial release
// ============================================================================
package reg_writeback_queue_pkg;

    localparam int c_data_width  = 16;
    localparam int c_select_size = 3;
    localparam int c_num_regs    = 1 << c_select_size;

endpackage : reg_writeback_queue_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Ordered storage for pending register writebacks with per-slot
//            occupancy so the top can compare every queued destination.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import reg_writeback_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = c_data_width,
    parameter int SELECT_SIZE = c_select_size,
    parameter int DEPTH       = 4,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              push_i,
    input  logic [SELECT_SIZE-1:0]            dst_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic                              pop_i,
    output logic [SELECT_SIZE-1:0]            head_dst_o,
    output logic [DATA_WIDTH-1:0]             head_data_o,
    output logic [PTR_W:0]                    count_o,
    output logic [DEPTH-1:0]                  occ_o,
    output logic [DEPTH-1:0][SELECT_SIZE-1:0] slot_dst_o
);

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W + 1)'(1);

    logic [SELECT_SIZE-1:0] r_dst_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]  r_data_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_count;

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_dst_mem[r_wr_ptr]  <= dst_i;
            r_data_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (pop_i)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_dst_o  = r_dst_mem[r_rd_ptr];
    assign head_data_o = r_data_mem[r_rd_ptr];
    assign count_o     = r_count;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [PTR_W-1:0] w_offset;
            // Distance from the head, modulo DEPTH, decides whether slot i is live.
            assign w_offset      = PTR_W'(i) - r_rd_ptr;
            assign occ_o[i]      = ({1'b0, w_offset} < r_count);
            assign slot_dst_o[i] = r_dst_mem[i];
        end
    endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue
// Purpose  : Queues register writebacks, drains one per cycle into an
//            active-low write strobe and reports read-after-write hazards.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = c_data_width,
    parameter int SELECT_SIZE = c_select_size,
    parameter int DEPTH       = 4,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   wb_valid_i,
    output logic                   wb_ready_o,
    input  logic [SELECT_SIZE-1:0] wb_dst_i,
    input  logic [DATA_WIDTH-1:0]  wb_data_i,
    input  logic                   stall_i,
    output logic                   reg_we_o,
    output logic [SELECT_SIZE-1:0] reg_dst_o,
    output logic [DATA_WIDTH-1:0]  reg_data_o,
    input  logic [SELECT_SIZE-1:0] chk_src1_i,
    input  logic [SELECT_SIZE-1:0] chk_src2_i,
    output logic                   hazard1_o,
    output logic                   hazard2_o,
    output logic [CNT_W-1:0]       count_o
);

    logic                             w_push;
    logic                             w_pop;
    logic [SELECT_SIZE-1:0]           w_head_dst;
    logic [DATA_WIDTH-1:0]            w_head_data;
    logic [CNT_W-1:0]                 w_count;
    logic [DEPTH-1:0]                 w_occ;
    logic [DEPTH-1:0][SELECT_SIZE-1:0] w_slot_dst;
    logic [DEPTH-1:0]                 w_hit1;
    logic [DEPTH-1:0]                 w_hit2;

    logic                   r_we_n;
    logic [SELECT_SIZE-1:0] r_dst;
    logic [DATA_WIDTH-1:0]  r_data;

    // Ready is decided on the pre-edge count, so a full queue refuses a push
    // even in the cycle it pops.
    assign wb_ready_o = (w_count < CNT_W'(DEPTH)) && reset_ni;
    assign w_push     = wb_valid_i && wb_ready_o;
    assign w_pop      = (w_count != '0) && !stall_i;

    wb_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SELECT_SIZE (SELECT_SIZE),
        .DEPTH       (DEPTH)
    ) u_wb_fifo (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .push_i      (w_push),
        .dst_i       (wb_dst_i),
        .data_i      (wb_data_i),
        .pop_i       (w_pop),
        .head_dst_o  (w_head_dst),
        .head_data_o (w_head_data),
        .count_o     (w_count),
        .occ_o       (w_occ),
        .slot_dst_o  (w_slot_dst)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_we_n <= 1'b1;
            r_dst  <= '0;
            r_data <= '0;
        end else begin
            r_we_n <= !w_pop;
            if (w_pop) begin
                r_dst  <= w_head_dst;
                r_data <= w_head_data;
            end
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
            assign w_hit1[i] = w_occ[i] && (w_slot_dst[i] == chk_src1_i);
            assign w_hit2[i] = w_occ[i] && (w_slot_dst[i] == chk_src2_i);
        end
    endgenerate

    // The write being strobed this cycle is not yet visible in the register file.
    assign hazard1_o = (|w_hit1) || (!r_we_n && (r_dst == chk_src1_i));
    assign hazard2_o = (|w_hit2) || (!r_we_n && (r_dst == chk_src2_i));

    assign reg_we_o   = r_we_n;
    assign reg_dst_o  = r_dst;
    assign reg_data_o = r_data;
    assign count_o    = w_count;

endmodule : reg_writeback_queue
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_queue
// Purpose  : Directed, scoreboard-checked bench for reg_writeback_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;

    localparam int DW    = 16;
    localparam int SS    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [SS-1:0] dst;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk_i      = 1'b0;
    logic          reset_ni   = 1'b0;
    logic          wb_valid_i = 1'b0;
    logic          stall_i    = 1'b0;
    logic [SS-1:0] wb_dst_i   = '0;
    logic [DW-1:0] wb_data_i  = '0;
    logic [SS-1:0] chk_src1_i = '0;
    logic [SS-1:0] chk_src2_i = '0;
    logic          wb_ready_o;
    logic          reg_we_o;
    logic [SS-1:0] reg_dst_o;
    logic [DW-1:0] reg_data_o;
    logic          hazard1_o;
    logic          hazard2_o;
    logic [CW-1:0] count_o;

    entry_t        sb[$];
    logic          exp_we   = 1'b1;
    logic [SS-1:0] exp_dst  = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] rf [8];
    int            n_cmp = 0;
    int            n_bad = 0;

    reg_writeback_queue #(
        .DATA_WIDTH  (DW),
        .SELECT_SIZE (SS),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .wb_valid_i (wb_valid_i),
        .wb_ready_o (wb_ready_o),
        .wb_dst_i   (wb_dst_i),
        .wb_data_i  (wb_data_i),
        .stall_i    (stall_i),
        .reg_we_o   (reg_we_o),
        .reg_dst_o  (reg_dst_o),
        .reg_data_o (reg_data_o),
        .chk_src1_i (chk_src1_i),
        .chk_src2_i (chk_src2_i),
        .hazard1_o  (hazard1_o),
        .hazard2_o  (hazard2_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic h1;
        logic h2;
        h1 = 1'b0;
        h2 = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].dst == chk_src1_i) h1 = 1'b1;
            if (sb[i].dst == chk_src2_i) h2 = 1'b1;
        end
        if (!exp_we && exp_dst == chk_src1_i) h1 = 1'b1;
        if (!exp_we && exp_dst == chk_src2_i) h2 = 1'b1;
        check({tag, ".we"},    32'(reg_we_o),   32'(exp_we));
        check({tag, ".dst"},   32'(reg_dst_o),  32'(exp_dst));
        check({tag, ".data"},  32'(reg_data_o), 32'(exp_data));
        check({tag, ".count"}, 32'(count_o),    32'(sb.size()));
        check({tag, ".ready"}, 32'(wb_ready_o), 32'((sb.size() < DEPTH) && reset_ni));
        check({tag, ".haz1"},  32'(hazard1_o),  32'(h1));
        check({tag, ".haz2"},  32'(hazard2_o),  32'(h2));
    endtask

    // One clock: inputs are already stable; the reference queue decides
    // acceptance and drain from its own occupancy.
    task automatic tick(input string tag);
        logic   acc;
        logic   pop;
        entry_t e;
        entry_t h;
        acc    = reset_ni && wb_valid_i && (sb.size() < DEPTH);
        pop    = reset_ni && (sb.size() > 0) && !stall_i;
        e.dst  = wb_dst_i;
        e.data = wb_data_i;
        @(posedge clk_i);
        if (!reset_ni) begin
            sb.delete();
            exp_we   = 1'b1;
            exp_dst  = '0;
            exp_data = '0;
        end else begin
            exp_we = !pop;
            if (pop) begin
                h        = sb.pop_front();
                exp_dst  = h.dst;
                exp_data = h.data;
            end
            if (acc) sb.push_back(e);
        end
        @(negedge clk_i);
        if (!reg_we_o) rf[reg_dst_o] = reg_data_o;
        check_outputs(tag);
    endtask

    task automatic offer(input logic [SS-1:0] dst, input logic [DW-1:0] data);
        wb_valid_i = 1'b1;
        wb_dst_i   = dst;
        wb_data_i  = data;
    endtask

    initial begin
        foreach (rf[i]) rf[i] = '0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check_outputs("reset");
        reset_ni = 1'b1;

        // Single push, minimum latency
        offer(3'd3, 16'hBEEF);
        tick("lat_push");
        wb_valid_i = 1'b0;
        tick("lat_strobe");
        check("lat_we_low", 32'(reg_we_o), 32'd0);
        check("lat_dst", 32'(reg_dst_o), 32'd3);
        check("lat_data", 32'(reg_data_o), 32'hBEEF);
        tick("lat_idle");
        check("lat_we_high", 32'(reg_we_o), 32'd1);

        // Fill under stall, refuse a fifth offer, then drain in order
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(3'(i), 16'h1000 + 16'(i));
            tick("fill");
        end
        offer(3'd7, 16'hDEAD);
        tick("full_offer");
        check("full_count", 32'(count_o), 32'd4);
        check("full_ready", 32'(wb_ready_o), 32'd0);
        wb_valid_i = 1'b0;
        stall_i    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("drain");
            check("drain_data", 32'(reg_data_o), 32'h1000 + 32'(i));
        end
        tick("drain_done");

        // Hazard tracking
        chk_src1_i = 3'd5;
        chk_src2_i = 3'd2;
        offer(3'd5, 16'h55AA);
        tick("haz_push");
        check("haz_queued", 32'(hazard1_o), 32'd1);
        wb_valid_i = 1'b0;
        tick("haz_strobe");
        check("haz_strobe1", 32'(hazard1_o), 32'd1);
        check("haz_strobe2", 32'(hazard2_o), 32'd0);
        tick("haz_after");
        check("haz_cleared", 32'(hazard1_o), 32'd0);

        // Duplicate destinations, back to back
        chk_src1_i = 3'd1;
        offer(3'd1, 16'h0001);
        tick("dup_a");
        offer(3'd1, 16'h0002);
        tick("dup_b");
        wb_valid_i = 1'b0;
        tick("dup_s1");
        tick("dup_s2");
        tick("dup_idle");
        check("dup_rf1", 32'(rf[1]), 32'h0002);

        // Full queue with stall released and a held offer
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(3'(4 + i), 16'hA000 + 16'(i));
            tick("f2_fill");
        end
        stall_i = 1'b0;
        offer(3'd2, 16'h2222);
        tick("f2_refused");
        check("f2_cnt3", 32'(count_o), 32'd3);
        tick("f2_accept");
        check("f2_cnt_hold", 32'(count_o), 32'd3);
        wb_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick("f2_drain");
        check("f2_last", 32'(reg_data_o), 32'h2222);

        // Mid-cycle reset with entries queued
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(3'(i), 16'hC000 + 16'(i));
            tick("rst_fill");
        end
        wb_valid_i = 1'b0;
        stall_i    = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        sb.delete();
        exp_we   = 1'b1;
        exp_dst  = '0;
        exp_data = '0;
        check_outputs("rst_async");
        @(negedge clk_i);
        reset_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("rst_after");
            check("rst_no_strobe", 32'(reg_we_o), 32'd1);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reg_writeback_queue
`default_nettype wire

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, meaning the register data width.
REQ-002 The module SHALL have parameter SELECT_SIZE, default 3, meaning the register-select width (8 registers).
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of 2, at least 2).
REQ-004 The module SHALL have port clk_i  input  1  meaning the single system clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port reset_ni  input  1  meaning reset, asynchronous and active-low.
REQ-006 The module SHALL have port wb_valid_i  input  1  meaning a writeback request is offered.
REQ-007 The module SHALL have port wb_ready_o  output  1  meaning the queue can accept a request.
REQ-008 The module SHALL have port wb_dst_i  input  SELECT_SIZE  meaning the destination register of the offered request.
REQ-009 The module SHALL have port wb_data_i  input  DATA_WIDTH  meaning the data of the offered request.
REQ-010 The module SHALL have port stall_i  input  1  meaning drain is held while high.
REQ-011 The module SHALL have port reg_we_o  output  1  meaning the register-file write strobe, active-low.
REQ-012 The module SHALL have port reg_dst_o  output  SELECT_SIZE  meaning the register-file destination select.
REQ-013 The module SHALL have port reg_data_o  output  DATA_WIDTH  meaning the register-file write data.
REQ-014 The module SHALL have ports chk_src1_i and chk_src2_i  input  SELECT_SIZE  meaning the register indices queried for hazards.
REQ-015 The module SHALL have ports hazard1_o and hazard2_o  output  1  meaning the matching query register has a pending write.
REQ-016 The module SHALL have port count_o  output  clog2(DEPTH)+1  meaning the current queue occupancy.

Function
REQ-017 A request SHALL be accepted on a rising edge where wb_valid_i=1 and wb_ready_o=1.
REQ-018 wb_ready_o SHALL be 1 exactly when count_o<DEPTH and reset_ni=1; when full, no push occurs even in a cycle where a pop occurs.
REQ-019 Entries SHALL drain strictly in acceptance order; duplicate destinations are allowed and are written in order.
REQ-020 On each rising edge with count_o>0 and stall_i=0, the head entry SHALL be popped into the registered outputs reg_dst_o and reg_data_o, and reg_we_o SHALL be 0 for exactly that following cycle.
REQ-021 In every other cycle reg_we_o SHALL be 1, and reg_dst_o and reg_data_o SHALL hold their last values.
REQ-022 The minimum latency SHALL be as follows: a request accepted at edge N drives reg_we_o=0 after edge N+1, so the register file captures it on the falling edge within that cycle.
REQ-023 A simultaneous push and pop SHALL leave count_o unchanged and preserve order; a push into an empty queue SHALL not bypass the queue.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 hazardN_o SHALL be combinational and equal 1 if chk_srcN_i matches the destination of any occupied entry, or matches reg_dst_o while reg_we_o=0.
REQ-026 stall_i=1 SHALL not block pushes; throughput SHALL be one pop per cycle when not stalled.

Reset
REQ-027 While reset_ni=0, the outputs SHALL be reg_we_o=1, reg_dst_o=0, reg_data_o=0, count_o=0, wb_ready_o=0 and hazard1_o=hazard2_o=0, with both pointers at 0.
REQ-028 A reset asserted mid-operation SHALL discard all queued entries and any in-flight write immediately, with no partial write strobe.
REQ-029 After reset_ni rises, the queue SHALL accept a request on the first rising edge.

Structure
REQ-030 The DATA_WIDTH and SELECT_SIZE defaults and the register-count constant SHALL live in the shared processor package.
REQ-031 Queue storage and pointers SHALL be a sub-module named wb_fifo; the write-strobe output stage and the hazard compare SHALL be in the top module.

Verification
REQ-032 After reset, push dst=3 data=0xBEEF -> one cycle later reg_we_o=0 for one cycle with reg_dst_o=3 and reg_data_o=0xBEEF, then reg_we_o=1.
REQ-033 With stall_i=1, push 4 entries -> count_o=4, wb_ready_o=0, a 5th offer is not accepted; release stall -> 4 consecutive write strobes in order.
REQ-034 Push dst=5 with chk_src1_i=5 and chk_src2_i=2 -> hazard1_o=1 and hazard2_o=0 until the cycle after the strobe, then hazard1_o=0.
REQ-035 Back-to-back pushes dst=1 data=0x0001 then dst=1 data=0x0002 -> two strobes in order, and the register file ends with 0x0002.
REQ-036 With 3 entries queued, pulse reset_ni low mid-cycle -> reg_we_o=1 immediately, count_o=0, and no further strobes.
REQ-037 Full queue with stall released and wb_valid_i held high -> push refused in the full cycle, and accepted on the next edge after count_o=3.
